// File: rtl/s3_chien_forney.sv
// s3_chien_forney: stage 3 of the RS(N,N-4) GF(2^8) decoder (t=2, poly 0x11D).
// Chien search over L(x)=l0+l1*x+l2*x^2 with Forney error values, emitted
// highest-degree symbol first.
// Optional build macro S3_CHIEN_ERRCNT_EN adds the err_cnt output (saturated root count).
module s3_chien_forney #(
    parameter int N   = 255,
    parameter int FCR = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       kes_done,
    input  logic [7:0] rs_lambda0,
    input  logic [7:0] rs_lambda1,
    input  logic [7:0] rs_lambda2,
    input  logic [7:0] rs_omega0,
    input  logic [7:0] rs_omega1,
    output logic       err_vld,
    output logic [7:0] err_pos,
    output logic [7:0] err_val,
    output logic       chien_done,
    output logic       decode_fail,
`ifdef S3_CHIEN_ERRCNT_EN
    output logic [1:0] err_cnt,
`endif
    output logic       kes_ovf
);

    // GF(2^8) multiply, primitive polynomial x^8+x^4+x^3+x^2+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    // alpha^e, used only to build elaboration-time constants
    function automatic logic [7:0] gf_pow(input int unsigned e);
        logic [7:0] r;
        r = 8'h01;
        for (int unsigned i = 0; i < e % 255; i++) r = gf_mul(r, 8'h02);
        return r;
    endfunction

    localparam int unsigned NM1   = N - 1;
    localparam int unsigned FCR_U = FCR;
    localparam logic [7:0] A_T1   = gf_pow((255 - NM1) % 255);        // a^-(N-1)
    localparam logic [7:0] A_T2   = gf_pow((510 - 2 * NM1) % 255);    // a^-2(N-1)
    localparam logic [7:0] A_X    = gf_pow((NM1 * (1 - FCR_U)) % 255); // a^((N-1)(1-FCR))
    localparam logic [7:0] A_STEP = gf_pow((255 - (1 - FCR_U)) % 255); // a^-(1-FCR)
    localparam logic [7:0] POS_LAST = 8'(NM1);
    localparam logic [7:0] INV_EXP  = 8'd254;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        INV    = 4'b0010,
        SEARCH = 4'b0100,
        FIN    = 4'b1000
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       accept;

    logic [7:0] l0, l1, l2, o0, o1;
    logic [7:0] inv;
    logic [7:0] t1, t2, w1, xr;
    logic [7:0] cnt;
    logic [1:0] roots;

    logic       inv_bit;
    logic [7:0] inv_sq;
    logic [7:0] inv_next;
    logic       root;
    logic [7:0] forney_val;
    logic [1:0] deg;
    logic       fail;

    // exponent bits are consumed MSB first: step cnt uses bit 7-cnt, i.e. ~cnt[2:0]
    assign inv_bit    = INV_EXP[~cnt[2:0]];
    assign inv_sq     = gf_mul(inv, inv);
    assign inv_next   = inv_bit ? gf_mul(inv_sq, l1) : inv_sq;
    assign root       = ((l0 ^ t1 ^ t2) == 8'h00);
    assign forney_val = gf_mul(gf_mul(o0 ^ w1, xr), inv);
    assign deg        = (l2 != 8'h00) ? 2'd2 : ((l1 != 8'h00) ? 2'd1 : 2'd0);
    assign fail       = (roots != deg) | ((roots != 2'd0) & (l1 == 8'h00));

`ifdef S3_CHIEN_ERRCNT_EN
    assign err_cnt = roots;
`endif

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // next-state decode and output generation
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        err_vld     = 1'b0;
        err_pos     = '0;
        err_val     = '0;
        chien_done  = 1'b0;
        decode_fail = 1'b0;
        kes_ovf     = 1'b0;
        case (state)
            IDLE: begin
                if (kes_done) begin
                    accept     = 1'b1;
                    state_next = INV;
                end
            end
            INV: begin
                kes_ovf = kes_done;
                if (cnt == 8'd7) state_next = SEARCH;
            end
            SEARCH: begin
                kes_ovf = kes_done;
                err_vld = 1'b1;
                err_pos = cnt;
                err_val = root ? forney_val : 8'h00;
                if (cnt == 8'd0) state_next = FIN;
            end
            FIN: begin
                kes_ovf     = kes_done;
                chien_done  = 1'b1;
                decode_fail = fail;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // coefficient latch, inversion, Chien term stepping and root counting
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            l0    <= '0;
            l1    <= '0;
            l2    <= '0;
            o0    <= '0;
            o1    <= '0;
            inv   <= '0;
            t1    <= '0;
            t2    <= '0;
            w1    <= '0;
            xr    <= '0;
            cnt   <= '0;
            roots <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        l0    <= rs_lambda0;
                        l1    <= rs_lambda1;
                        l2    <= rs_lambda2;
                        o0    <= rs_omega0;
                        o1    <= rs_omega1;
                        inv   <= 8'h01;
                        cnt   <= '0;
                        roots <= '0;
                    end
                end
                INV: begin
                    inv <= inv_next;
                    t1  <= gf_mul(l1, A_T1);
                    t2  <= gf_mul(l2, A_T2);
                    w1  <= gf_mul(o1, A_T1);
                    xr  <= A_X;
                    cnt <= (cnt == 8'd7) ? POS_LAST : cnt + 8'd1;
                end
                SEARCH: begin
                    t1 <= gf_mul(t1, 8'h02);
                    t2 <= gf_mul(t2, 8'h04);
                    w1 <= gf_mul(w1, 8'h02);
                    xr <= gf_mul(xr, A_STEP);
                    if (root && roots != 2'd3) roots <= roots + 2'd1;
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
